des_uart_cmd_rx: RTL and testbench

- UART receive front-end for the DES demo.
- Accepts ASCII-hex command lines typed in the terminal: "K" + 16 hex digits loads the 64-bit key; "P" + 16 hex digits loads the 64-bit plaintext.
- Drives the DES key/data inputs in place of the switch selector. It is the inbound counterpart of the existing hex-dump UART transmit path and shares its baud rate and ASCII-hex format.

---
 rtl/des_uart_pkg.sv | 43 ++++
 rtl/des_uart_cmd_rx_uart_rx.sv | 138 +++++++++++++
 rtl/des_uart_cmd_rx.sv | 151 +++++++++++++++
 tb/tb_des_uart_cmd_rx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/des_uart_pkg.sv
// des_uart_pkg
//   Shared definitions for the DES demo UART command receiver:
//   baud divisor helper, ASCII constants, parser state / target enums and the
//   ASCII-hex to nibble decoder (inverse of the transmit nibble-to-ASCII map).
package des_uart_pkg;

    function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                      input int unsigned baud);
        return clk_freq / baud;
    endfunction

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_K     = 8'h4B;
    localparam logic [7:0] ASCII_K_LC  = 8'h6B;
    localparam logic [7:0] ASCII_P     = 8'h50;
    localparam logic [7:0] ASCII_P_LC  = 8'h70;

    typedef enum logic [1:0] {
        IDLE,
        HEX,
        DISCARD
    } parse_state_t;

    typedef enum logic {
        TGT_KEY,
        TGT_MSG
    } target_t;

    function automatic logic is_hex(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) ||
               (c >= 8'h41 && c <= 8'h46) ||
               (c >= 8'h61 && c <= 8'h66);
    endfunction

    // Valid only when is_hex(c). Letters A-F/a-f have low nibble 1..6 and bit 6 set,
    // so adding 9 yields 10..15; digits have bit 6 clear and map directly.
    function automatic logic [3:0] hex_to_nibble(input logic [7:0] c);
        return c[3:0] + (c[6] ? 4'd9 : 4'd0);
    endfunction

endpackage

// File: rtl/des_uart_cmd_rx_uart_rx.sv
// uart_rx
//   8N1 bit-level UART receiver with 2-flop input synchronizer.
//   Ports:
//     clk, rst      - system clock, async active-high reset
//     rx            - serial input, idle high, asynchronous to clk
//     rx_data[7:0]  - last received byte (valid with rx_valid)
//     rx_valid      - 1-cycle strobe, byte received with good stop bit
//     frame_err     - 1-cycle strobe, stop bit sampled low (byte dropped)
//
//   state    | meaning
//   RX_IDLE  | waiting for a 1->0 edge on the synced line
//   RX_START | half-bit wait, confirm start bit still low
//   RX_DATA  | sampling 8 data bits, LSB first
//   RX_STOP  | sampling stop bit, then back to RX_IDLE
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int unsigned HALF = CLKS_PER_BIT / 2;
    localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    rx_state_t       state, state_n;
    logic [TW-1:0]   timer, timer_n;
    logic [2:0]      bit_idx, bit_idx_n;
    logic [7:0]      shreg, shreg_n;
    logic            valid_n, ferr_n;

    logic            rx_meta, rx_sync;
    logic [1:0]      sync_ok;
    logic            rx_hi;
    logic            start_edge;

    // sync_ok marks when rx_sync holds a real sample rather than its reset value,
    // so a line held low through reset release is not mistaken for a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            sync_ok <= 2'b00;
            rx_hi   <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            sync_ok <= {sync_ok[0], 1'b1};
            rx_hi   <= sync_ok[1] & rx_sync;
        end
    end

    assign start_edge = rx_hi & ~rx_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RX_IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            bit_idx   <= bit_idx_n;
            shreg     <= shreg_n;
            rx_valid  <= valid_n;
            frame_err <= ferr_n;
        end
    end

    always_comb begin
        state_n   = state;
        timer_n   = timer;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        valid_n   = 1'b0;
        ferr_n    = 1'b0;
        case (state)
            RX_IDLE: begin
                if (start_edge) begin
                    state_n = RX_START;
                    timer_n = TW'(HALF - 1);
                end
            end
            RX_START: begin
                if (timer == '0) begin
                    if (rx_sync) begin
                        state_n = RX_IDLE;
                    end else begin
                        state_n   = RX_DATA;
                        timer_n   = TW'(CLKS_PER_BIT - 1);
                        bit_idx_n = 3'd0;
                    end
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            RX_DATA: begin
                if (timer == '0) begin
                    shreg_n = {rx_sync, shreg[7:1]};
                    timer_n = TW'(CLKS_PER_BIT - 1);
                    if (bit_idx == 3'd7) begin
                        state_n = RX_STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            RX_STOP: begin
                if (timer == '0) begin
                    valid_n = rx_sync;
                    ferr_n  = ~rx_sync;
                    state_n = RX_IDLE;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

    assign rx_data = shreg;

endmodule

// File: rtl/des_uart_cmd_rx.sv
// des_uart_cmd_rx
//   Receives ASCII-hex command lines over UART: "K"/"k" + 16 hex digits loads
//   the DES key, "P"/"p" + 16 hex digits loads the plaintext. Lines end in CR
//   or LF; spaces inside a line are ignored.
//   Ports:
//     clk, rst   - system clock, async active-high reset
//     rx         - UART serial input
//     key_out    - last committed key        key_valid - 1-cycle update pulse
//     msg_out    - last committed plaintext  msg_valid - 1-cycle update pulse
//     cmd_err    - 1-cycle pulse, malformed line (at most one per line)
//     frame_err  - 1-cycle pulse, bad stop bit
//     busy       - parser is inside a line (state != IDLE)
//
//   state   | meaning
//   IDLE    | between lines; waiting for a command letter
//   HEX     | collecting hex digits for the latched target
//   DISCARD | line rejected; skipping to the next CR/LF
module des_uart_cmd_rx
    import des_uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [63:0] key_out,
    output logic [63:0] msg_out,
    output logic        key_valid,
    output logic        msg_valid,
    output logic        cmd_err,
    output logic        frame_err,
    output logic        busy
);

    localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(rx_frame_err)
    );

    assign frame_err = rx_frame_err;

    parse_state_t state, state_n;
    target_t      target, target_n;
    logic [4:0]   count, count_n;
    logic [63:0]  shift, shift_n;
    logic         err_n;
    logic         commit;

    logic         c_hex, c_term, c_space, c_cmd;
    target_t      c_tgt;

    always_comb begin
        c_hex   = is_hex(rx_data);
        c_term  = (rx_data == ASCII_CR) || (rx_data == ASCII_LF);
        c_space = (rx_data == ASCII_SPACE);
        c_cmd   = (rx_data == ASCII_K) || (rx_data == ASCII_K_LC) ||
                  (rx_data == ASCII_P) || (rx_data == ASCII_P_LC);
        c_tgt   = ((rx_data == ASCII_P) || (rx_data == ASCII_P_LC)) ? TGT_MSG : TGT_KEY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            target    <= TGT_KEY;
            count     <= '0;
            shift     <= '0;
            key_out   <= '0;
            msg_out   <= '0;
            key_valid <= 1'b0;
            msg_valid <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            state     <= state_n;
            target    <= target_n;
            count     <= count_n;
            shift     <= shift_n;
            cmd_err   <= err_n;
            key_valid <= commit && (target == TGT_KEY);
            msg_valid <= commit && (target == TGT_MSG);
            if (commit && target == TGT_KEY) key_out <= shift;
            if (commit && target == TGT_MSG) msg_out <= shift;
        end
    end

    always_comb begin
        state_n  = state;
        target_n = target;
        count_n  = count;
        shift_n  = shift;
        err_n    = 1'b0;
        commit   = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    if (c_cmd) begin
                        state_n  = HEX;
                        count_n  = 5'd0;
                        target_n = c_tgt;
                    end else if (!(c_term || c_space)) begin
                        err_n   = 1'b1;
                        state_n = DISCARD;
                    end
                end
            end
            HEX: begin
                // A corrupted byte mid-line invalidates the whole line.
                if (rx_frame_err) begin
                    err_n   = 1'b1;
                    state_n = DISCARD;
                end else if (rx_valid) begin
                    if (c_hex) begin
                        if (count == 5'd16) begin
                            err_n   = 1'b1;
                            state_n = DISCARD;
                        end else begin
                            shift_n = {shift[59:0], hex_to_nibble(rx_data)};
                            count_n = count + 5'd1;
                        end
                    end else if (c_term) begin
                        state_n = IDLE;
                        if (count == 5'd16) commit = 1'b1;
                        else                err_n  = 1'b1;
                    end else if (!c_space) begin
                        err_n   = 1'b1;
                        state_n = DISCARD;
                    end
                end
            end
            DISCARD: begin
                if (rx_valid && c_term) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_des_uart_cmd_rx.sv
module tb_des_uart_cmd_rx;

    localparam int CPB = 24;   // 2_400_000 / 100_000

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic [63:0] key_out, msg_out;
    logic        key_valid, msg_valid, cmd_err, frame_err, busy;

    des_uart_cmd_rx #(
        .CLK_FREQ(2_400_000),
        .BAUD    (100_000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .key_out  (key_out),
        .msg_out  (msg_out),
        .key_valid(key_valid),
        .msg_valid(msg_valid),
        .cmd_err  (cmd_err),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // tgt: 0 = no commit, 1 = key, 2 = msg
    typedef struct {
        string       body;
        logic [7:0]  t1;
        logic [7:0]  t2;
        int          tgt;
        logic [63:0] val;
        int          errs;
    } vec_t;

    typedef struct {
        int          tgt;
        logic [63:0] val;
    } exp_t;

    vec_t        vecs[$];
    exp_t        exp_q[$];
    exp_t        e;
    logic [63:0] key_m = '0;
    logic [63:0] msg_m = '0;

    int cyc = 0;
    int last_strobe = -10;
    int strobe_cnt = 0;
    int cmd_err_cnt = 0;
    int ferr_cnt = 0;
    logic prev_pulse = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard side: every commit pulse pops the oldest expected commit.
    always @(negedge clk) begin
        if (dut.rx_valid) begin
            strobe_cnt++;
            last_strobe = cyc;
        end
        if (cmd_err)   cmd_err_cnt++;
        if (frame_err) ferr_cnt++;
        if (key_valid || msg_valid) begin
            check("valid_width", {63'b0, prev_pulse}, 64'd0);
            check("commit_latency", 64'(cyc), 64'(last_strobe + 1));
            if (exp_q.size() == 0) begin
                check("unexpected_commit", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("commit_kind", key_valid ? 64'd1 : 64'd2, 64'(e.tgt));
                if (e.tgt == 1) key_m = e.val;
                else            msg_m = e.val;
                check("commit_key", key_out, key_m);
                check("commit_msg", msg_out, msg_m);
            end
        end
        prev_pulse = key_valid | msg_valid;
    end

    task automatic idle_bits(input int n);
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        if (!stop) repeat (CPB) @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    function automatic void add_vec(input string body, input logic [7:0] t1, input logic [7:0] t2,
                                    input int tgt, input logic [63:0] val, input int errs);
        vec_t v;
        v.body = body; v.t1 = t1; v.t2 = t2; v.tgt = tgt; v.val = val; v.errs = errs;
        vecs.push_back(v);
    endfunction

    initial begin
        #(150_000 * 10);
        $display("FAIL watchdog: run exceeded cycle budget, checks %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, f0, s0;
        exp_t x;

        add_vec("K133457799BBCDFF1",    8'h0D, 8'h00, 1, 64'h133457799BBCDFF1, 0);
        add_vec("p0123456789abcdef",    8'h0D, 8'h0A, 2, 64'h0123456789ABCDEF, 0);
        add_vec("K0123 4567 89AB CDEF", 8'h0A, 8'h00, 1, 64'h0123456789ABCDEF, 0);
        add_vec("K12G4",                8'h0D, 8'h00, 0, 64'h0, 1);
        add_vec("K123456789ABCDEF",     8'h0D, 8'h00, 0, 64'h0, 1);
        add_vec("K0123456789ABCDEF0",   8'h0D, 8'h00, 0, 64'h0, 1);
        add_vec("KFFFFFFFFFFFFFFFF",    8'h0D, 8'h00, 1, 64'hFFFFFFFFFFFFFFFF, 0);
        add_vec("kfedcba9876543210",    8'h0D, 8'h00, 1, 64'hFEDCBA9876543210, 0);
        add_vec("  ",                   8'h0D, 8'h0A, 0, 64'h0, 0);
        add_vec("X",                    8'h0D, 8'h00, 0, 64'h0, 1);
        add_vec("PK",                   8'h0D, 8'h00, 0, 64'h0, 1);

        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_key", key_out, 64'h0);
        check("rst_msg", msg_out, 64'h0);
        check("rst_pulses_busy", {60'b0, key_valid, msg_valid, cmd_err, frame_err | busy}, 64'h0);
        rst = 1'b0;
        idle_bits(2);

        foreach (vecs[i]) begin
            e0 = cmd_err_cnt;
            if (vecs[i].tgt != 0) begin
                x.tgt = vecs[i].tgt;
                x.val = vecs[i].val;
                exp_q.push_back(x);
            end
            send_str(vecs[i].body);
            send_byte(vecs[i].t1, 1'b1);
            if (vecs[i].t2 != 8'h00) send_byte(vecs[i].t2, 1'b1);
            idle_bits(2);
            check($sformatf("v%0d_cmd_err", i), 64'(cmd_err_cnt - e0), 64'(vecs[i].errs));
            check($sformatf("v%0d_commit_seen", i), 64'(exp_q.size()), 64'd0);
            check($sformatf("v%0d_key", i), key_out, key_m);
            check($sformatf("v%0d_msg", i), msg_out, msg_m);
            check($sformatf("v%0d_busy", i), {63'b0, busy}, 64'd0);
        end

        // Bad stop bit in the middle of a line.
        e0 = cmd_err_cnt;
        f0 = ferr_cnt;
        send_str("P0011");
        check("frame_busy_mid", {63'b0, busy}, 64'd1);
        send_byte(8'h32, 1'b0);
        send_str("2233445566778");
        send_byte(8'h0D, 1'b1);
        idle_bits(2);
        check("frame_ferr", 64'(ferr_cnt - f0), 64'd1);
        check("frame_cmd_err", 64'(cmd_err_cnt - e0), 64'd1);
        check("frame_msg", msg_out, msg_m);
        check("frame_no_commit", 64'(exp_q.size()), 64'd0);
        check("frame_busy_end", {63'b0, busy}, 64'd0);

        // Short low glitch on an idle line.
        e0 = cmd_err_cnt;
        s0 = strobe_cnt;
        rx = 1'b0;
        repeat (10) @(negedge clk);
        rx = 1'b1;
        idle_bits(3);
        check("glitch_strobe", 64'(strobe_cnt - s0), 64'd0);
        check("glitch_cmd_err", 64'(cmd_err_cnt - e0), 64'd0);
        check("glitch_busy", {63'b0, busy}, 64'd0);

        // Reset mid-line with rx held low across release.
        send_str("P12345678");
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        key_m = '0;
        msg_m = '0;
        s0 = strobe_cnt;
        f0 = ferr_cnt;
        idle_bits(12);
        check("rstlow_key", key_out, 64'h0);
        check("rstlow_msg", msg_out, 64'h0);
        check("rstlow_busy", {63'b0, busy}, 64'd0);
        check("rstlow_strobe", 64'(strobe_cnt - s0), 64'd0);
        check("rstlow_ferr", 64'(ferr_cnt - f0), 64'd0);
        rx = 1'b1;
        idle_bits(2);
        x.tgt = 2;
        x.val = 64'hA5A5A5A5A5A5A5A5;
        exp_q.push_back(x);
        send_str("PA5A5A5A5A5A5A5A5");
        send_byte(8'h0D, 1'b1);
        idle_bits(2);
        check("post_rst_commit_seen", 64'(exp_q.size()), 64'd0);
        check("post_rst_msg", msg_out, 64'hA5A5A5A5A5A5A5A5);
        check("post_rst_key", key_out, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
